// File: rtl/stream_xbar_pkg.sv
// rtl/stream_xbar_pkg.sv - shared types and round-robin pick helper for the stream crossbar
// Contents: arb_state_e (per-output arbiter state), RR_MAX_PORTS (widest request
// vector rr_pick handles), rr_pick (first requester at or after a pointer, cyclic).
package stream_xbar_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    localparam int RR_MAX_PORTS = 32;

    // Returns the first set bit of req[n-1:0] at or after ptr, wrapping at n.
    // Scanning from the far end down lets the nearest hit overwrite the result.
    function automatic int rr_pick(input logic [RR_MAX_PORTS-1:0] req, input int ptr, input int n);
        int idx;
        rr_pick = 0;
        for (int k = RR_MAX_PORTS - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx[4:0]]) begin
                    rr_pick = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/return_arbiter.sv
// rtl/return_arbiter.sv - per-output packet arbiter: IDLE/LOCKED FSM, grant and round-robin pointer
// Ports: clk_i/rst_i clock and async active-high reset; req_i one bit per input
// requesting this output; accept_i a beat of the granted input is taken this cycle;
// last_i that beat ends the packet; locked_o a packet is in progress; gnt_o granted input.
module return_arbiter
    import stream_xbar_pkg::*;
#(
    parameter int M_DATA_COUNT = 3,
    parameter int T_DEST_WIDTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [M_DATA_COUNT-1:0] req_i,
    input  logic                    accept_i,
    input  logic                    last_i,
    output logic                    locked_o,
    output logic [T_DEST_WIDTH-1:0] gnt_o
);

    arb_state_e              r_state;
    arb_state_e              w_state_next;
    logic [T_DEST_WIDTH-1:0] r_gnt;
    logic [T_DEST_WIDTH-1:0] w_gnt_next;
    logic [T_DEST_WIDTH-1:0] r_ptr;
    logic [T_DEST_WIDTH-1:0] w_ptr_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                // Arbitration cycle: no beat is taken, only the grant is chosen.
                if (|req_i) begin
                    w_gnt_next   = T_DEST_WIDTH'(rr_pick(RR_MAX_PORTS'(req_i), int'(r_ptr), M_DATA_COUNT));
                    w_state_next = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (accept_i && last_i) begin
                    w_state_next = ST_IDLE;
                    w_ptr_next   = (r_gnt == T_DEST_WIDTH'(M_DATA_COUNT - 1)) ? '0
                                                                            : r_gnt + T_DEST_WIDTH'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign locked_o = (r_state == ST_LOCKED);
    assign gnt_o    = r_gnt;

endmodule

// File: rtl/stream_return_router.sv
// rtl/stream_return_router.sv - routes tagged master-side response packets back to slave-side outputs
// Ports: clk_i/rst_i clock and async active-high reset; r_* master-side inputs
// (flat vectors, input i at slice i); s_* registered slave-side outputs with the
// sourcing input index on s_src_o; drop_o pulses for each beat discarded for an
// out-of-range ID.
module stream_return_router
    import stream_xbar_pkg::*;
#(
    parameter int  T_DATA_WIDTH = 8,
    parameter int  S_DATA_COUNT = 2,
    parameter int  M_DATA_COUNT = 3,
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [T_DATA_WIDTH*M_DATA_COUNT-1:0] r_data_i,
    input  logic [T_ID___WIDTH*M_DATA_COUNT-1:0] r_id_i,
    input  logic [M_DATA_COUNT-1:0]              r_last_i,
    input  logic [M_DATA_COUNT-1:0]              r_valid_i,
    output logic [M_DATA_COUNT-1:0]              r_ready_o,
    output logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_data_o,
    output logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_src_o,
    output logic [S_DATA_COUNT-1:0]              s_last_o,
    output logic [S_DATA_COUNT-1:0]              s_valid_o,
    input  logic [S_DATA_COUNT-1:0]              s_ready_i,
    output logic [M_DATA_COUNT-1:0]              drop_o
);

    logic [T_ID___WIDTH-1:0] w_id       [M_DATA_COUNT];
    logic [M_DATA_COUNT-1:0] w_oor;
    logic [M_DATA_COUNT-1:0] w_req      [S_DATA_COUNT];
    logic                    w_locked   [S_DATA_COUNT];
    logic [T_DEST_WIDTH-1:0] w_gnt      [S_DATA_COUNT];
    logic                    w_out_rdy  [S_DATA_COUNT];
    logic                    w_sel_valid[S_DATA_COUNT];
    logic                    w_accept   [S_DATA_COUNT];
    logic                    w_acc_last [S_DATA_COUNT];
    logic [T_DATA_WIDTH-1:0] w_acc_data [S_DATA_COUNT];
    logic [M_DATA_COUNT-1:0] w_ready;

    logic [T_DATA_WIDTH-1:0] r_out_data [S_DATA_COUNT];
    logic [T_DEST_WIDTH-1:0] r_out_src  [S_DATA_COUNT];
    logic                    r_out_last [S_DATA_COUNT];
    logic                    r_out_valid[S_DATA_COUNT];

    // ID decode; the extra leading zero keeps the range compare unsigned at full width.
    always_comb begin
        w_oor = '0;
        for (int i = 0; i < M_DATA_COUNT; i++) begin
            w_id[i]  = r_id_i[i*T_ID___WIDTH +: T_ID___WIDTH];
            w_oor[i] = r_valid_i[i] &&
                       ({1'b0, w_id[i]} >= (T_ID___WIDTH+1)'(S_DATA_COUNT));
        end
    end

    always_comb begin
        for (int j = 0; j < S_DATA_COUNT; j++) begin
            w_req[j] = '0;
            for (int i = 0; i < M_DATA_COUNT; i++) begin
                w_req[j][i] = r_valid_i[i] && ({1'b0, w_id[i]} == (T_ID___WIDTH+1)'(j));
            end
        end
    end

    for (genvar g = 0; g < S_DATA_COUNT; g++) begin : g_arb
        return_arbiter #(
            .M_DATA_COUNT(M_DATA_COUNT),
            .T_DEST_WIDTH(T_DEST_WIDTH)
        ) u_arb (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .req_i   (w_req[g]),
            .accept_i(w_accept[g]),
            .last_i  (w_acc_last[g]),
            .locked_o(w_locked[g]),
            .gnt_o   (w_gnt[g])
        );
    end

    // Granted-input mux per output. The granted input may take a beat whenever the
    // output register is empty or being drained this cycle.
    always_comb begin
        for (int j = 0; j < S_DATA_COUNT; j++) begin
            w_sel_valid[j] = 1'b0;
            w_acc_last[j]  = 1'b0;
            w_acc_data[j]  = '0;
            for (int i = 0; i < M_DATA_COUNT; i++) begin
                if (w_gnt[j] == T_DEST_WIDTH'(i)) begin
                    w_sel_valid[j] = r_valid_i[i];
                    w_acc_last[j]  = r_last_i[i];
                    w_acc_data[j]  = r_data_i[i*T_DATA_WIDTH +: T_DATA_WIDTH];
                end
            end
            w_out_rdy[j] = w_locked[j] && (!r_out_valid[j] || s_ready_i[j]);
            w_accept[j]  = w_out_rdy[j] && w_sel_valid[j];
        end
    end

    // An input's ID picks a single output, so at most one output drives its ready.
    always_comb begin
        w_ready = w_oor;
        for (int j = 0; j < S_DATA_COUNT; j++) begin
            for (int i = 0; i < M_DATA_COUNT; i++) begin
                if (w_out_rdy[j] && (w_gnt[j] == T_DEST_WIDTH'(i))) begin
                    w_ready[i] = 1'b1;
                end
            end
        end
    end

    assign r_ready_o = w_ready;
    assign drop_o    = w_oor;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                r_out_data[j]  <= '0;
                r_out_src[j]   <= '0;
                r_out_last[j]  <= 1'b0;
                r_out_valid[j] <= 1'b0;
            end
        end else begin
            for (int j = 0; j < S_DATA_COUNT; j++) begin
                if (w_accept[j]) begin
                    r_out_data[j]  <= w_acc_data[j];
                    r_out_src[j]   <= w_gnt[j];
                    r_out_last[j]  <= w_acc_last[j];
                    r_out_valid[j] <= 1'b1;
                end else if (s_ready_i[j]) begin
                    r_out_valid[j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        s_data_o  = '0;
        s_src_o   = '0;
        s_last_o  = '0;
        s_valid_o = '0;
        for (int j = 0; j < S_DATA_COUNT; j++) begin
            s_data_o[j*T_DATA_WIDTH +: T_DATA_WIDTH] = r_out_data[j];
            s_src_o[j*T_DEST_WIDTH +: T_DEST_WIDTH]  = r_out_src[j];
            s_last_o[j]                              = r_out_last[j];
            s_valid_o[j]                             = r_out_valid[j];
        end
    end

endmodule

// File: tb/tb_stream_return_router.sv
// tb/tb_stream_return_router.sv - scoreboard bench for stream_return_router
module tb_stream_return_router;

    localparam int W  = 8;
    localparam int S  = 3;
    localparam int M  = 3;
    localparam int IW = 2;
    localparam int DW = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
        logic          last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [W*M-1:0] r_data_i;
    logic [IW*M-1:0] r_id_i;
    logic [M-1:0]   r_last_i;
    logic [M-1:0]   r_valid_i;
    logic [M-1:0]   r_ready_o;
    logic [W*S-1:0] s_data_o;
    logic [DW*S-1:0] s_src_o;
    logic [S-1:0]   s_last_o;
    logic [S-1:0]   s_valid_o;
    logic [S-1:0]   s_ready_i;
    logic [M-1:0]   drop_o;

    beat_t pend [M][$];
    beat_t expq [S][M][$];

    int       total = 0;
    int       bad = 0;
    int       cyc = 0;
    int       ndrop = 0;
    bit       rand_mode = 1'b0;
    logic [S-1:0] dir_ready = '1;

    stream_return_router #(
        .T_DATA_WIDTH(W),
        .S_DATA_COUNT(S),
        .M_DATA_COUNT(M)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .r_data_i (r_data_i),
        .r_id_i   (r_id_i),
        .r_last_i (r_last_i),
        .r_valid_i(r_valid_i),
        .r_ready_o(r_ready_o),
        .s_data_o (s_data_o),
        .s_src_o  (s_src_o),
        .s_last_o (s_last_o),
        .s_valid_o(s_valid_o),
        .s_ready_i(s_ready_i),
        .drop_o   (drop_o)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [W-1:0] out_data(input int j);
        return s_data_o[j*W +: W];
    endfunction

    function automatic logic [DW-1:0] out_src(input int j);
        return s_src_o[j*DW +: DW];
    endfunction

    task automatic push_pkt(input int i, input int id, input int len, input int base);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.id   = IW'(id);
            b.data = W'(base + k);
            b.last = (k == len - 1);
            pend[i].push_back(b);
        end
    endtask

    function automatic int outstanding();
        int n = 0;
        for (int i = 0; i < M; i++) begin
            n += pend[i].size();
            for (int j = 0; j < S; j++) n += expq[j][i].size();
        end
        return n;
    endfunction

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_in_valid(input int i, input string name);
        int k = 0;
        @(negedge clk);
        while (!r_valid_i[i] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(r_valid_i[i]), 1);
    endtask

    task automatic wait_out_valid(input int j, input string name);
        int k = 0;
        @(negedge clk);
        while (!s_valid_o[j] && k < 100) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(s_valid_o[j]), 1);
    endtask

    // Driver: presents the head of each input's packet queue, holds it until the
    // handshake, and records every accepted in-range beat as expected on its output.
    initial begin
        bit    acc [M];
        beat_t b;
        r_valid_i = '0;
        r_data_i  = '0;
        r_id_i    = '0;
        r_last_i  = '0;
        s_ready_i = '1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < M; i++) begin
                acc[i] = 1'b0;
                if (r_valid_i[i] && int'(r_id_i[i*IW +: IW]) < S)
                    check("drop_quiet", 32'(drop_o[i]), 0);
                if (!rst_i && r_valid_i[i] && r_ready_o[i] && pend[i].size() > 0) begin
                    acc[i] = 1'b1;
                    b = pend[i].pop_front();
                    if (int'(b.id) >= S) begin
                        check("drop_pulse", 32'(drop_o[i]), 1);
                        ndrop++;
                    end else begin
                        expq[b.id][i].push_back(b);
                    end
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < M; i++) begin
                if (pend[i].size() > 0 &&
                    ((r_valid_i[i] && !acc[i]) || !rand_mode || $urandom_range(3) != 0)) begin
                    r_valid_i[i]          = 1'b1;
                    r_data_i[i*W +: W]    = pend[i][0].data;
                    r_id_i[i*IW +: IW]    = pend[i][0].id;
                    r_last_i[i]           = pend[i][0].last;
                end else begin
                    r_valid_i[i] = 1'b0;
                end
            end
            for (int j = 0; j < S; j++)
                s_ready_i[j] = rand_mode ? ($urandom_range(3) != 0) : dir_ready[j];
        end
    end

    // Monitor: pops the expected beat for (output, source) on every output
    // handshake, checks packets are not interleaved and stalled beats stay put.
    initial begin
        logic [W+DW:0] held [S];
        bit            stalled [S];
        int            owner [S];
        beat_t         e;
        int            src;
        for (int j = 0; j < S; j++) begin
            stalled[j] = 1'b0;
            owner[j]   = -1;
            held[j]    = '0;
        end
        forever begin
            @(negedge clk);
            if (rst_i) begin
                for (int j = 0; j < S; j++) begin
                    stalled[j] = 1'b0;
                    owner[j]   = -1;
                end
            end else begin
                for (int j = 0; j < S; j++) begin
                    if (stalled[j]) begin
                        check("stall_valid_hold", 32'(s_valid_o[j]), 1);
                        if (s_valid_o[j])
                            check("stall_fields_hold", 32'({out_data(j), out_src(j), s_last_o[j]}),
                                  32'(held[j]));
                    end
                    stalled[j] = 1'b0;
                    if (s_valid_o[j]) begin
                        if (!s_ready_i[j]) begin
                            stalled[j] = 1'b1;
                            held[j]    = {out_data(j), out_src(j), s_last_o[j]};
                        end else begin
                            src = int'(out_src(j));
                            check("src_in_range", 32'(src < M), 1);
                            if (src < M) begin
                                check("beat_expected", 32'(expq[j][src].size() != 0), 1);
                                if (expq[j][src].size() != 0) begin
                                    e = expq[j][src].pop_front();
                                    check("beat_data", 32'(out_data(j)), 32'(e.data));
                                    check("beat_last", 32'(s_last_o[j]), 32'(e.last));
                                    if (owner[j] >= 0) check("packet_atomic", src, owner[j]);
                                    owner[j] = s_last_o[j] ? -1 : src;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int last_c;
        int nd0;
        int id;
        int k;
        bit exp_v;

        rst_i = 1'b1;
        settle(3);
        check("rst_valid", 32'(s_valid_o), 0);
        check("rst_last", 32'(s_last_o), 0);
        check("rst_data", 32'(s_data_o), 0);
        check("rst_src", 32'(s_src_o), 0);
        check("rst_ready", 32'(r_ready_o), 0);
        check("rst_drop", 32'(drop_o), 0);
        rst_i = 1'b0;
        settle(2);

        // Single 3-beat packet, input 1 -> output 0, exact latency.
        push_pkt(1, 0, 3, 'hA1);
        wait_in_valid(1, "t1_start");
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            exp_v = (c >= 2 && c <= 4);
            check("t1_valid", 32'(s_valid_o[0]), 32'(exp_v));
            if (exp_v) begin
                check("t1_data", 32'(out_data(0)), 32'('hA0 + c - 1));
                check("t1_src", 32'(out_src(0)), 1);
                check("t1_last", 32'(s_last_o[0]), 32'(c == 4));
            end
        end
        settle(4);

        // All inputs send 1-beat packets to output 1: round-robin, one idle cycle between.
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < M; i++)
                push_pkt(i, 1, 1, 'h20 + 3 * r + i);
        n = 0;
        last_c = 0;
        k = 0;
        while (k < 80 && n < 9) begin
            @(negedge clk);
            if (s_valid_o[1]) begin
                check("t2_src_rr", 32'(out_src(1)), n % 3);
                if (n > 0) check("t2_gap", cyc - last_c, 2);
                last_c = cyc;
                n++;
            end
            k++;
        end
        check("t2_count", n, 9);
        settle(4);

        // Two outputs stream in parallel.
        push_pkt(0, 0, 4, 'h40);
        push_pkt(2, 1, 4, 'h50);
        wait_in_valid(0, "t3_start");
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            check("t3_valid", 32'(s_valid_o[1:0]), (c >= 2 && c <= 5) ? 3 : 0);
        end
        settle(4);

        // Downstream stall of 5 cycles mid-packet.
        push_pkt(1, 0, 6, 'h60);
        wait_out_valid(0, "t4_first");
        check("t4_first_data", 32'(out_data(0)), 'h60);
        dir_ready[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t4_valid", 32'(s_valid_o[0]), 1);
            check("t4_hold_data", 32'(out_data(0)), 'h61);
            check("t4_in_ready", 32'(r_ready_o[1]), 0);
        end
        dir_ready[0] = 1'b1;
        settle(12);
        check("t4_drained", expq[0][1].size() + pend[1].size(), 0);

        // Out-of-range ID is dropped with a pulse per beat.
        nd0 = ndrop;
        push_pkt(2, 3, 3, 'h70);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (r_valid_i[2]) begin
                check("t5_ready", 32'(r_ready_o[2]), 1);
                check("t5_drop", 32'(drop_o[2]), 1);
            end
            check("t5_no_out", 32'(s_valid_o), 0);
        end
        check("t5_drops", ndrop - nd0, 3);

        // Reset mid-packet: output clears at once, arbitration restarts from pointer 0.
        push_pkt(0, 0, 6, 'h80);
        wait_out_valid(0, "t6_first");
        #2;
        rst_i = 1'b1;
        #1;
        check("t6_valid_clear", 32'(s_valid_o), 0);
        check("t6_ready_low", 32'(r_ready_o), 0);
        for (int i = 0; i < M; i++) begin
            pend[i].delete();
            for (int j = 0; j < S; j++) expq[j][i].delete();
        end
        settle(2);
        rst_i = 1'b0;
        push_pkt(1, 0, 1, 'h91);
        push_pkt(2, 0, 1, 'h92);
        wait_out_valid(0, "t6_after");
        check("t6_rr_from_0", 32'(out_src(0)), 1);
        check("t6_data", 32'(out_data(0)), 'h91);
        settle(6);

        // Random traffic with random gaps and back-pressure.
        rand_mode = 1'b1;
        for (int i = 0; i < M; i++) begin
            for (int p = 0; p < 25; p++) begin
                id = ($urandom_range(9) == 0) ? 3 : int'($urandom_range(2));
                push_pkt(i, id, int'($urandom_range(4, 1)), int'($urandom_range(255)));
            end
        end
        k = 0;
        while (k < 20000 && outstanding() != 0) begin
            @(negedge clk);
            k++;
        end
        check("rand_drained", outstanding(), 0);
        rand_mode = 1'b0;
        settle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
